// File: rtl/exp7_exibe_sequencia.sv
`default_nettype none
// ============================================================================
//  Module   : exp7_exibe_sequencia
//  Brief    : Plays the stored colour sequence (addresses 0..rodada) on the
//             LEDs, each value lit for T_ACESO cycles followed by a
//             T_APAGADO-cycle blank gap. It pulses pronto when finished.
//  Options  : EXIBE_ABORTAR_EN adds the abortar input, which cancels a
//             running sequence and returns the block to OCIOSO.
//  Revision : 1.0 - initial release
// ============================================================================
module exp7_exibe_sequencia #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
`ifdef EXIBE_ABORTAR_EN
    input  logic              abortar,
`endif
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // State codes double as the db_estado debug value.
    localparam logic [3:0] c_OCIOSO  = 4'd0;
    localparam logic [3:0] c_ACESO   = 4'd1;
    localparam logic [3:0] c_APAGADO = 4'd2;
    localparam logic [3:0] c_FIM     = 4'd3;

    // One extra bit on top of the longest interval, so the counter cannot wrap.
    localparam int c_T_MAX   = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int c_TIMER_W = $clog2(c_T_MAX) + 1;

    localparam logic [c_TIMER_W-1:0] c_ACESO_ULT   = c_TIMER_W'(T_ACESO - 1);
    localparam logic [c_TIMER_W-1:0] c_APAGADO_ULT = c_TIMER_W'(T_APAGADO - 1);

    logic [3:0]           r_estado;
    logic [c_TIMER_W-1:0] r_timer;
    logic [ADDR_W-1:0]    r_endereco;
    logic [ADDR_W-1:0]    r_rodada;
    logic                 w_abortar;

`ifdef EXIBE_ABORTAR_EN
    assign w_abortar = abortar;
`else
    assign w_abortar = 1'b0;
`endif

    // Sequencer: start handshake, lit/blank timing, address stepping and abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= c_OCIOSO;
            r_timer    <= '0;
            r_endereco <= '0;
            r_rodada   <= '0;
        end else begin
            case (r_estado)
                c_OCIOSO: begin
                    // abortar is meaningless here; iniciar alone decides.
                    if (iniciar) begin
                        r_rodada   <= rodada;
                        r_endereco <= '0;
                        r_timer    <= '0;
                        r_estado   <= c_ACESO;
                    end
                end
                c_ACESO: begin
                    if (w_abortar) begin
                        r_endereco <= '0;
                        r_timer    <= '0;
                        r_estado   <= c_OCIOSO;
                    end else if (r_timer == c_ACESO_ULT) begin
                        r_timer  <= '0;
                        r_estado <= c_APAGADO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_APAGADO: begin
                    if (w_abortar) begin
                        r_endereco <= '0;
                        r_timer    <= '0;
                        r_estado   <= c_OCIOSO;
                    end else if (r_timer == c_APAGADO_ULT) begin
                        r_timer <= '0;
                        // Stop on the last round's address; never step past it.
                        if (r_endereco == r_rodada) begin
                            r_estado <= c_FIM;
                        end else begin
                            r_endereco <= r_endereco + 1'b1;
                            r_estado   <= c_ACESO;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_FIM: begin
                    // endereco keeps the last shown address after a normal end.
                    if (w_abortar) begin
                        r_endereco <= '0;
                        r_timer    <= '0;
                    end
                    r_estado <= c_OCIOSO;
                end
                default: begin
                    r_timer  <= '0;
                    r_estado <= c_OCIOSO;
                end
            endcase
        end
    end

    // Output decode straight from the state register, so reset clears it at once.
    always_comb begin
        leds      = '0;
        exibindo  = 1'b0;
        pronto    = 1'b0;
        db_estado = r_estado;
        endereco  = r_endereco;
        case (r_estado)
            c_ACESO: begin
                leds     = dado_memoria;
                exibindo = 1'b1;
            end
            c_APAGADO: begin
                exibindo = 1'b1;
            end
            c_FIM: begin
                // An aborted FIM suppresses the completion pulse.
                pronto = ~w_abortar;
            end
            default: begin
                leds = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
